// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
//   Definitions shared by the calculator blocks: the ALU opcode encodings,
//   the sequencer state type, and small opcode classification helpers.
// ---------------------------------------------------------------------------
package calc_pkg;

    // ALU opcode encodings. The 8-bit ALU slice decodes these values directly.
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Operators the sequencer knows how to run.
    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_CMP);
    endfunction

    // Operators whose carry/borrow-in is meaningful (low pass uses in_cin).
    function automatic logic op_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/calc16_sequencer.sv
// ---------------------------------------------------------------------------
// calc16_sequencer
//   Runs one 16-bit operation through an external combinational 8-bit ALU in
//   two byte passes (low, then high), chaining carry/borrow between them.
//   COMPARE is computed as B-A; the final borrow is set exactly when A > B.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            request handshake (ready only in IDLE)
//   in_a, in_b [15:0]            operands
//   in_op [2:0], in_cin          operator, carry/borrow-in (ADD/SUB only)
//   alu_a, alu_b [7:0]           ALU operand drives
//   alu_cs [2:0], alu_cin        ALU opcode and carry-in drives
//   alu_result [7:0], alu_carry  ALU outputs (combinational from alu_*)
//   out_valid/out_ready          result handshake
//   out_result [15:0]            result
//   out_carry, out_zero          final carry/borrow and zero (ADD/SUB only)
//   out_err                      illegal operator
// ---------------------------------------------------------------------------
module calc16_sequencer (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [2:0]  in_op,
    input  logic        in_cin,

    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_cs,
    output logic        alu_cin,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_carry,
    output logic        out_zero,
    output logic        out_err
);
    import calc_pkg::*;

    state_t      state;
    state_t      state_next;

    // Captured request, frozen from acceptance until the result is consumed.
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [2:0]  op_q;
    logic        cin_q;

    // Carry/borrow out of the low pass, fed into the high pass.
    logic        chain_q;

    logic        is_cmp;
    logic        is_arith;

    assign is_cmp   = (op_q == OP_CMP);
    assign is_arith = op_arith(op_q);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches when a branch leaves state_next unassigned.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = op_legal(in_op) ? ST_LO : ST_DONE;
                end
            end
            ST_LO:   state_next = ST_HI;
            ST_HI:   state_next = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: handshakes and ALU drive
    // -----------------------------------------------------------------------
    always_comb begin
        // IDLE/DONE park the ALU on a decoded opcode with zero operands.
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_cs    = OP_AND;
        alu_cin   = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_LO: begin
                // COMPARE runs B-A so the final borrow means A > B.
                alu_a   = is_cmp ? b_q[7:0] : a_q[7:0];
                alu_b   = is_cmp ? a_q[7:0] : b_q[7:0];
                alu_cs  = is_cmp ? OP_SUB : op_q;
                alu_cin = is_arith ? cin_q : 1'b0;
            end
            ST_HI: begin
                alu_a   = is_cmp ? b_q[15:8] : a_q[15:8];
                alu_b   = is_cmp ? a_q[15:8] : b_q[15:8];
                alu_cs  = is_cmp ? OP_SUB : op_q;
                alu_cin = (is_arith || is_cmp) ? chain_q : 1'b0;
            end
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Capture and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            op_q       <= OP_AND;
            cin_q      <= 1'b0;
            chain_q    <= 1'b0;
            out_result <= 16'h0000;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        op_q  <= in_op;
                        cin_q <= in_cin;
                        if (op_legal(in_op)) begin
                            out_err <= 1'b0;
                        end else begin
                            // Illegal operator skips both passes.
                            out_result <= 16'h0000;
                            out_carry  <= 1'b0;
                            out_zero   <= 1'b0;
                            out_err    <= 1'b1;
                        end
                    end
                end
                ST_LO: begin
                    out_result[7:0] <= alu_result;
                    chain_q         <= alu_carry;
                end
                ST_HI: begin
                    if (is_cmp) begin
                        out_result <= {15'b0, alu_carry};
                        out_carry  <= 1'b0;
                        out_zero   <= 1'b0;
                    end else begin
                        out_result[15:8] <= alu_result;
                        out_carry        <= is_arith ? alu_carry : 1'b0;
                        out_zero         <= is_arith &&
                                            ({alu_result, out_result[7:0]} == 16'h0000);
                    end
                end
                default: ;  // DONE holds every output until consumed
            endcase
        end
    end

endmodule

// File: tb/tb_calc16_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc16_sequencer
//   Directed bench for calc16_sequencer with a behavioural 8-bit ALU slice
//   wired to the alu_* ports. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_calc16_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_op;
    logic        in_cin;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_cs;
    logic        alu_cin;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_carry;
    logic        out_zero;
    logic        out_err;

    int n_checks = 0;
    int n_fail   = 0;

    calc16_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_cin     (in_cin),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cs     (alu_cs),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU slice; for SUB the carry output is the borrow.
    always_comb begin
        logic [8:0] wide;
        wide       = 9'h000;
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        case (alu_cs)
            3'b001: alu_result = alu_a & alu_b;
            3'b010: alu_result = alu_a | alu_b;
            3'b011: begin
                wide       = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
                alu_result = wide[7:0];
                alu_carry  = wide[8];
            end
            3'b100: begin
                wide       = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
                alu_result = wide[7:0];
                alu_carry  = wide[8];
            end
            default: ;
        endcase
    end

    // Issues one request at a negedge, scrambles the inputs right after the
    // accept edge, and waits (bounded) for out_valid. Leaves the DUT in DONE
    // with out_ready low. lo_* record the ALU drive seen one cycle after accept.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic cin,
                          output int lat, output logic [7:0] lo_a,
                          output logic [2:0] lo_cs, output logic lo_cin);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_cin   = cin;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 16'hA5A5;
        in_b     = 16'h5A5A;
        in_op    = 3'b011;
        in_cin   = ~cin;
        lo_a     = alu_a;
        lo_cs    = alu_cs;
        lo_cin   = alu_cin;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 16'h0000;
        in_b      = 16'h0000;
        in_op     = 3'b000;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_result, out_carry, out_zero, out_err} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h c=%b z=%b e=%b, want rdy=1 vld=0 res=0000 c=0 z=0 e=0",
                     in_ready, out_valid, out_result, out_carry, out_zero, out_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({alu_a, alu_b, alu_cs, alu_cin} !== {8'h00, 8'h00, 3'b001, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_alu_drive: got a=%h b=%h cs=%b cin=%b, want a=00 b=00 cs=001 cin=0",
                     alu_a, alu_b, alu_cs, alu_cin);
        end
    endtask

    task automatic test_add();
        int lat; logic [7:0] la; logic [2:0] lc; logic lci;
        run_op(16'h00FF, 16'h0001, 3'b011, 1'b0, lat, la, lc, lci);
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL add_latency: got %0d cycles, want 3", lat);
        end
        n_checks++;
        if ({out_result, out_carry, out_zero, out_err} !== {16'h0100, 3'b000}) begin
            n_fail++;
            $display("FAIL add_00ff_0001: got res=%h c=%b z=%b e=%b, want res=0100 c=0 z=0 e=0",
                     out_result, out_carry, out_zero, out_err);
        end
        release_result();
        run_op(16'hFFFF, 16'h0001, 3'b011, 1'b0, lat, la, lc, lci);
        n_checks++;
        if ({out_result, out_carry, out_zero} !== {16'h0000, 2'b11}) begin
            n_fail++;
            $display("FAIL add_ffff_0001: got res=%h c=%b z=%b, want res=0000 c=1 z=1",
                     out_result, out_carry, out_zero);
        end
        release_result();
        // Carry-in is honoured on the low pass: 0x1000 + 0x0FFF + 1.
        run_op(16'h1000, 16'h0FFF, 3'b011, 1'b1, lat, la, lc, lci);
        n_checks++;
        if ({out_result, out_carry, out_zero, lci} !== {16'h2000, 3'b001}) begin
            n_fail++;
            $display("FAIL add_cin: got res=%h c=%b z=%b lo_cin=%b, want res=2000 c=0 z=0 lo_cin=1",
                     out_result, out_carry, out_zero, lci);
        end
        release_result();
    endtask

    task automatic test_sub();
        int lat; logic [7:0] la; logic [2:0] lc; logic lci;
        run_op(16'h0000, 16'h0001, 3'b100, 1'b0, lat, la, lc, lci);
        n_checks++;
        if ({out_result, out_carry, out_zero, lc} !== {16'hFFFF, 2'b10, 3'b100}) begin
            n_fail++;
            $display("FAIL sub_0000_0001: got res=%h c=%b z=%b lo_cs=%b, want res=ffff c=1 z=0 lo_cs=100",
                     out_result, out_carry, out_zero, lc);
        end
        release_result();
    endtask

    task automatic test_compare();
        int lat; logic [7:0] la; logic [2:0] lc; logic lci;
        run_op(16'h1234, 16'h1233, 3'b101, 1'b0, lat, la, lc, lci);
        n_checks++;
        if ({out_result, out_carry, out_zero, out_err} !== {16'h0001, 3'b000}) begin
            n_fail++;
            $display("FAIL cmp_gt: got res=%h c=%b z=%b e=%b, want res=0001 c=0 z=0 e=0",
                     out_result, out_carry, out_zero, out_err);
        end
        // Low pass must be SUB with B in the A slot and no carry-in.
        n_checks++;
        if ({la, lc, lci} !== {8'h33, 3'b100, 1'b0}) begin
            n_fail++;
            $display("FAIL cmp_lo_drive: got a=%h cs=%b cin=%b, want a=33 cs=100 cin=0", la, lc, lci);
        end
        release_result();
        run_op(16'h1234, 16'h1234, 3'b101, 1'b1, lat, la, lc, lci);
        n_checks++;
        if ({out_result, out_zero} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL cmp_equal: got res=%h z=%b, want res=0000 z=0", out_result, out_zero);
        end
        release_result();
        run_op(16'h00FF, 16'h0100, 3'b101, 1'b0, lat, la, lc, lci);
        n_checks++;
        if (out_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL cmp_lt_byte_cross: got res=%h, want 0000", out_result);
        end
        release_result();
    endtask

    task automatic test_logic();
        int lat; logic [7:0] la; logic [2:0] lc; logic lci;
        run_op(16'hF0F0, 16'h3C3C, 3'b001, 1'b1, lat, la, lc, lci);
        n_checks++;
        if ({out_result, out_carry, out_zero, lci} !== {16'h3030, 3'b000}) begin
            n_fail++;
            $display("FAIL and_f0f0_3c3c: got res=%h c=%b z=%b lo_cin=%b, want res=3030 c=0 z=0 lo_cin=0",
                     out_result, out_carry, out_zero, lci);
        end
        release_result();
        run_op(16'hF0F0, 16'h3C3C, 3'b010, 1'b0, lat, la, lc, lci);
        n_checks++;
        if ({out_result, out_carry, out_zero} !== {16'hFCFC, 2'b00}) begin
            n_fail++;
            $display("FAIL or_f0f0_3c3c: got res=%h c=%b z=%b, want res=fcfc c=0 z=0",
                     out_result, out_carry, out_zero);
        end
        // Handshake completes in cycle N, in_ready is high in cycle N+1.
        release_result();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL ready_after_handshake: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_illegal_backpressure();
        int lat; logic [7:0] la; logic [2:0] lc; logic lci;
        logic [19:0] snap;
        int changed;
        run_op(16'h1111, 16'h2222, 3'b111, 1'b1, lat, la, lc, lci);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL illegal_latency: got %0d cycles, want 1", lat);
        end
        n_checks++;
        if ({out_valid, out_err, out_result, out_carry, out_zero} !== {2'b11, 16'h0000, 2'b00}) begin
            n_fail++;
            $display("FAIL illegal_result: got vld=%b e=%b res=%h c=%b z=%b, want vld=1 e=1 res=0000 c=0 z=0",
                     out_valid, out_err, out_result, out_carry, out_zero);
        end
        snap    = {out_valid, out_err, out_result, out_carry, out_zero};
        changed = 0;
        // New requests offered during DONE must be ignored.
        in_valid = 1'b1;
        in_op    = 3'b011;
        repeat (5) begin
            @(negedge clk);
            if ({out_valid, out_err, out_result, out_carry, out_zero} !== snap || in_ready !== 1'b0)
                changed++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (changed !== 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %0d cycles with changed outputs or in_ready=1, want 0", changed);
        end
        release_result();
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [7:0] la; logic [2:0] lc; logic lci;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        in_op    = 3'b011;
        in_cin   = 1'b0;
        @(negedge clk);             // now in LO
        in_valid = 1'b0;
        @(negedge clk);             // now in HI
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, out_result} !== {2'b01, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_in_hi: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=0000",
                     out_valid, in_ready, out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0001, 3'b011, 1'b0, lat, la, lc, lci);
        n_checks++;
        if ({lat == 3, out_result, out_carry, out_zero, out_err} !== {1'b1, 16'h0002, 3'b000}) begin
            n_fail++;
            $display("FAIL add_after_reset: got lat=%0d res=%h c=%b z=%b e=%b, want lat=3 res=0002 c=0 z=0 e=0",
                     lat, out_result, out_carry, out_zero, out_err);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_compare();
        test_logic();
        test_illegal_backpressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
